// File: rtl/dht11_bit_receiver.sv
// DHT11 serial frame receiver.
// After the start-signal stage reports a completed response handshake, this
// block times every low/high phase of the DHT11 data line. It decodes 40 bits
// MSB first, verifies the checksum byte, and publishes the four data bytes.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle pulse: response handshake done, frame follows
//   dht_in          raw (asynchronous) DHT11 data line
//   humidity_int/dec, temp_int/dec   last accepted frame contents
//   data_valid      one-cycle pulse, new data on the outputs this cycle
//   checksum_err    one-cycle pulse, frame rejected (outputs kept)
//   timeout_err     one-cycle pulse, a line phase lasted too long (outputs kept)
//   busy            high whenever a frame is being received or checked
module dht11_bit_receiver #(
  parameter int unsigned TICKS_PER_US   = 50,
  parameter int unsigned BIT1_THRESH_US = 50,
  parameter int unsigned TIMEOUT_US     = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       data_valid,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam logic [15:0] THRESH_TICKS  = 16'(BIT1_THRESH_US * TICKS_PER_US);
  localparam logic [15:0] TIMEOUT_TICKS = 16'(TIMEOUT_US * TICKS_PER_US);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  state_t      state;
  logic        sync1, sync2, sync_d;
  logic [15:0] phase_cnt;
  logic [15:0] phase_inc;
  logic [5:0]  bit_cnt;
  logic [39:0] shift_reg;
  logic [7:0]  byte_sum;
  logic        fall, rise;
  logic        bit_is_one;

  assign fall = sync_d & ~sync2;
  assign rise = ~sync_d & sync2;

  // phase_inc is the length of the current phase including this cycle, so
  // a high phase of N cycles compares as N against the threshold.
  always_comb begin
    phase_inc  = (phase_cnt == '1) ? phase_cnt : phase_cnt + 16'd1;
    bit_is_one = (phase_inc > THRESH_TICKS);
    byte_sum   = shift_reg[39:32] + shift_reg[31:24]
               + shift_reg[23:16] + shift_reg[15:8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      sync_d       <= 1'b1;
      phase_cnt    <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      humidity_int <= '0;
      humidity_dec <= '0;
      temp_int     <= '0;
      temp_dec     <= '0;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync1        <= dht_in;
      sync2        <= sync1;
      sync_d       <= sync2;
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;

      case (state)
        IDLE: begin
          phase_cnt <= '0;
          if (start) begin
            state     <= WAIT_LOW;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            shift_reg <= '0;
          end
        end

        WAIT_LOW, BIT_LOW, BIT_HIGH: begin
          phase_cnt <= phase_inc;
          // Timeout is tested first so it wins over an edge in the same cycle.
          if (phase_cnt >= TIMEOUT_TICKS) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            phase_cnt   <= '0;
          end else if (state == WAIT_LOW && fall) begin
            state     <= BIT_LOW;
            phase_cnt <= '0;
          end else if (state == BIT_LOW && rise) begin
            state     <= BIT_HIGH;
            phase_cnt <= '0;
          end else if (state == BIT_HIGH && fall) begin
            shift_reg <= {shift_reg[38:0], bit_is_one};
            bit_cnt   <= bit_cnt + 6'd1;
            phase_cnt <= '0;
            state     <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
          end
        end

        CHECK: begin
          if (byte_sum == shift_reg[7:0]) begin
            humidity_int <= shift_reg[39:32];
            humidity_dec <= shift_reg[31:24];
            temp_int     <= shift_reg[23:16];
            temp_dec     <= shift_reg[15:8];
            data_valid   <= 1'b1;
          end else begin
            checksum_err <= 1'b1;
          end
          state     <= IDLE;
          busy      <= 1'b0;
          phase_cnt <= '0;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          phase_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_bit_receiver.sv
// Self-checking bench for dht11_bit_receiver. Runs with one tick per
// microsecond so whole 40-bit frames stay short. Line waveforms are built
// from per-bit low/high widths; expected data is decoded from those widths
// by the bench's own rule (high width > 50 us means 1) and checked against
// the byte-sum checksum.
module tb_dht11_bit_receiver;

  localparam int unsigned TPU    = 1;
  localparam int unsigned THRESH = 50 * TPU;
  localparam int unsigned TMO    = 200 * TPU;

  logic       clk = 1'b0;
  logic       rst, start, dht_in;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       data_valid, checksum_err, timeout_err, busy;

  dht11_bit_receiver #(.TICKS_PER_US(TPU)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dht_in       (dht_in),
    .humidity_int (humidity_int),
    .humidity_dec (humidity_dec),
    .temp_int     (temp_int),
    .temp_dec     (temp_dec),
    .data_valid   (data_valid),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0, n_fail = 0;
  int unsigned n_dv = 0, n_ck = 0, n_to = 0, n_multi = 0;

  always @(negedge clk) begin
    if (data_valid)   n_dv++;
    if (checksum_err) n_ck++;
    if (timeout_err)  n_to++;
    if (32'(data_valid) + 32'(checksum_err) + 32'(timeout_err) > 1) n_multi++;
  end

  int unsigned hw[40];
  int unsigned lw[40];
  logic [31:0] exp_out = '0;

  typedef struct {
    logic [39:0] frame;
    int unsigned w1;
    int unsigned w0;
    int unsigned kind;     // 0: data_valid expected, 1: checksum_err expected
    logic [31:0] out;      // {hum_int, hum_dec, temp_int, temp_dec} afterwards
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int unsigned n);
    dht_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_bits(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      hold(1'b0, lw[i]);
      hold(1'b1, hw[i]);
    end
  endtask

  task automatic plan_fixed(input logic [39:0] frame, input int unsigned w1, input int unsigned w0);
    for (int i = 0; i < 40; i++) begin
      hw[i] = frame[39-i] ? w1 : w0;
      lw[i] = 50 * TPU;
    end
  endtask

  task automatic plan_random(input logic [39:0] frame);
    for (int i = 0; i < 40; i++) begin
      hw[i] = frame[39-i] ? $urandom_range(85 * TPU, THRESH + 1) : $urandom_range(THRESH, 20 * TPU);
      lw[i] = $urandom_range(60 * TPU, 40 * TPU);
    end
  endtask

  // Reference decode: what a DHT11 receiver should read from the planned widths.
  function automatic logic [39:0] decode();
    logic [39:0] d;
    d = '0;
    for (int i = 0; i < 40; i++) d[39-i] = (hw[i] > THRESH);
    return d;
  endfunction

  task automatic run_frame();
    pulse_start();
    hold(1'b1, 20 * TPU);
    send_bits(0, 39);
    hold(1'b0, 50 * TPU);
    hold(1'b1, 30 * TPU);
  endtask

  task automatic check_events(input string name, input int unsigned s_dv, input int unsigned s_ck,
                              input int unsigned s_to, input int unsigned e_dv,
                              input int unsigned e_ck, input int unsigned e_to);
    check({name, "_events"}, {16'(n_dv - s_dv), 16'(n_ck - s_ck), 16'(n_to - s_to)},
          {16'(e_dv), 16'(e_ck), 16'(e_to)});
  endtask

  task automatic check_outputs(input string name);
    check({name, "_data"}, {humidity_int, humidity_dec, temp_int, temp_dec}, exp_out);
    check({name, "_busy"}, busy, 1'b0);
  endtask

  // Sends the planned frame and derives the expected result from the model.
  task automatic model_frame(input string name);
    logic [39:0] d;
    logic [7:0]  sum;
    int unsigned s_dv, s_ck, s_to;
    d   = decode();
    sum = d[39:32] + d[31:24] + d[23:16] + d[15:8];
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    run_frame();
    if (sum == d[7:0]) begin
      exp_out = d[39:8];
      check_events(name, s_dv, s_ck, s_to, 1, 0, 0);
    end else begin
      check_events(name, s_dv, s_ck, s_to, 0, 1, 0);
    end
    check_outputs(name);
  endtask

  initial begin
    int unsigned s_dv, s_ck, s_to, k;
    logic        found;
    logic [31:0] rb;
    logic [7:0]  good;

    vecs[0] = '{40'h37_00_18_00_4F, 70, 27, 0, 32'h37_00_18_00};
    vecs[1] = '{40'h37_00_18_00_50, 70, 27, 1, 32'h37_00_18_00};
    vecs[2] = '{40'h12_34_56_78_14, 51, 50, 0, 32'h12_34_56_78};
    vecs[3] = '{40'h37_00_18_00_4F, 50, 27, 0, 32'h00_00_00_00};
    vecs[4] = '{40'hFF_FF_FF_FF_FC, 70, 27, 0, 32'hFF_FF_FF_FF};
    vecs[5] = '{40'h01_02_03_04_0B, 70, 27, 1, 32'hFF_FF_FF_FF};

    rst = 1'b1; start = 1'b0; dht_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", {humidity_int, humidity_dec, temp_int, temp_dec}, 32'h0);
    check("reset_flags", {data_valid, checksum_err, timeout_err, busy}, 4'b0000);
    rst = 1'b0;
    hold(1'b1, 5);

    // Bad checksum straight after reset: outputs must stay zero.
    plan_fixed(40'h37_00_18_00_50, 70, 27);
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    run_frame();
    check_events("ck_after_reset", s_dv, s_ck, s_to, 0, 1, 0);
    check_outputs("ck_after_reset");

    for (int v = 0; v < 6; v++) begin
      plan_fixed(vecs[v].frame, vecs[v].w1, vecs[v].w0);
      s_dv = n_dv; s_ck = n_ck; s_to = n_to;
      run_frame();
      check_events($sformatf("vec%0d", v), s_dv, s_ck, s_to,
                   (vecs[v].kind == 0) ? 1 : 0, (vecs[v].kind == 1) ? 1 : 0, 0);
      exp_out = vecs[v].out;
      check_outputs($sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      rb   = $urandom;
      good = rb[31:24] + rb[23:16] + rb[15:8] + rb[7:0];
      if ($urandom_range(1, 0) == 1) good = good + 8'd1 + 8'($urandom_range(254, 0));
      plan_random({rb, good});
      model_frame($sformatf("rand%0d", r));
    end

    // Line stuck high after start: timeout from WAIT_LOW.
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    dht_in = 1'b1;
    pulse_start();
    k = 0; found = 1'b0;
    while (k < TMO + 50 && !found) begin
      @(posedge clk);
      #1;
      k++;
      if (timeout_err) found = 1'b1;
    end
    check("wait_timeout_seen", found, 1'b1);
    check("wait_timeout_latency", (k >= TMO - 1 && k <= TMO + 2), 1'b1);
    hold(1'b1, 50 * TPU);
    check_events("wait_timeout", s_dv, s_ck, s_to, 0, 0, 1);
    check_outputs("wait_timeout");

    // High phase stuck mid-frame: timeout from BIT_HIGH, outputs kept.
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    pulse_start();
    hold(1'b1, 20 * TPU);
    hold(1'b0, 50 * TPU);
    hold(1'b1, 250 * TPU);
    hold(1'b0, 50 * TPU);
    hold(1'b1, 30 * TPU);
    check_events("bit_timeout", s_dv, s_ck, s_to, 0, 0, 1);
    check_outputs("bit_timeout");

    // Reset after bit 20 of a good frame; remainder of the line is ignored.
    plan_fixed(40'h41_05_1A_02_62, 70, 27);
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    pulse_start();
    hold(1'b1, 20 * TPU);
    send_bits(0, 19);
    hold(1'b0, 10);
    check("busy_mid_frame", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_out = '0;
    check_outputs("mid_reset");
    hold(1'b0, 40 * TPU);
    hold(1'b1, hw[20]);
    send_bits(21, 39);
    hold(1'b0, 50 * TPU);
    hold(1'b1, 30 * TPU);
    check_events("mid_reset", s_dv, s_ck, s_to, 0, 0, 0);
    check_outputs("after_reset_frame");

    // A second start pulse during the frame must not disturb it.
    plan_fixed(40'h41_05_1A_02_62, 70, 27);
    s_dv = n_dv; s_ck = n_ck; s_to = n_to;
    fork
      run_frame();
      begin
        repeat (1500) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    join
    exp_out = 32'h41_05_1A_02;
    check_events("double_start", s_dv, s_ck, s_to, 1, 0, 0);
    check_outputs("double_start");

    check("pulse_exclusive", n_multi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dht11_bit_receiver.md
DHT11_BIT_RECEIVER -- requirements
Module: dht11_bit_receiver

Interface
REQ-001 Parameter TICKS_PER_US, default 50: clk cycles per microsecond.
REQ-002 Parameter BIT1_THRESH_US, default 50: a high phase longer than this many us decodes as 1, otherwise 0.
REQ-003 Parameter TIMEOUT_US, default 200: maximum duration of any single line phase before abort.
REQ-004 clk  in  1  single system clock; all logic on the rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse from the start-signal stage, meaning the DHT11 response handshake has completed.
REQ-007 dht_in  in  1  asynchronous DHT11 data line, sampled as an input only.
REQ-008 humidity_int  out  8  relative humidity, integer byte.
REQ-009 humidity_dec  out  8  relative humidity, decimal byte.
REQ-010 temp_int  out  8  temperature, integer byte.
REQ-011 temp_dec  out  8  temperature, decimal byte.
REQ-012 data_valid  out  1  one-cycle pulse when a frame is accepted.
REQ-013 checksum_err  out  1  one-cycle pulse when the frame checksum mismatches.
REQ-014 timeout_err  out  1  one-cycle pulse when a phase exceeds TIMEOUT_US.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 dht_in passes through a 2-flop synchronizer; all edge detection uses the synchronized signal and its 1-cycle delayed copy.
REQ-017 Edge detection latency: 3 clk cycles from a dht_in transition to the edge being acted on.
REQ-018 States: IDLE, WAIT_LOW, BIT_LOW, BIT_HIGH, CHECK.
REQ-019 IDLE -> WAIT_LOW on start=1; bit counter and shift register cleared; phase counter cleared.
REQ-020 WAIT_LOW -> BIT_LOW on a falling edge (end of the response-high phase, start of bit 0).
REQ-021 BIT_LOW -> BIT_HIGH on a rising edge; phase counter cleared.
REQ-022 BIT_HIGH on a falling edge:
  - shift in 1 if phase counter > BIT1_THRESH_US*TICKS_PER_US, else shift in 0; MSB first.
  - increment the bit counter and clear the phase counter.
  - go to CHECK if this was bit 40, else go to BIT_LOW.
REQ-023 Phase counter is 16 bits, counts every cycle in WAIT_LOW/BIT_LOW/BIT_HIGH, saturates, and is cleared on every state change.
REQ-024 In WAIT_LOW, BIT_LOW or BIT_HIGH, if the phase counter reaches TIMEOUT_US*TICKS_PER_US: pulse timeout_err, go to IDLE, and leave the data outputs unchanged.
REQ-025 Frame byte order: humidity_int, humidity_dec, temp_int, temp_dec, checksum (bits 1-8 ... 33-40).
REQ-026 CHECK is a single cycle. If (sum of the four data bytes) mod 256 == checksum byte: load all four output registers and pulse data_valid; otherwise pulse checksum_err with outputs unchanged. Then go to IDLE.
REQ-027 data_valid and the new output values appear in the same cycle.
REQ-028 start is ignored while busy=1.
REQ-029 A timeout has priority over a simultaneous edge in the same cycle.
REQ-030 At most one of data_valid, checksum_err, timeout_err is high in any cycle.

Reset
REQ-031 rst=1 at a clock edge forces IDLE from any state, including mid-frame.
REQ-032 On reset: all data outputs 0x00; data_valid, checksum_err, timeout_err and busy all 0; counters and shift register 0; synchronizer flops 1 (line idle high).
REQ-033 No frame in progress at reset produces a pulse after reset is released.

Verification
REQ-034 Good frame 0x37,0x00,0x18,0x00,0x4F (low 50us, high 27us for 0 / 70us for 1) -> one data_valid pulse; humidity_int=55, temp_int=24, both dec bytes 0.
REQ-035 Same frame with checksum 0x50 -> one checksum_err pulse; outputs keep their prior values (0x00 after reset).
REQ-036 start, then dht_in held high for 250us -> timeout_err pulse about 200us after entry to WAIT_LOW; busy returns to 0.
REQ-037 rst asserted after bit 20 of a good frame -> all outputs 0 and busy=0 the next cycle; no pulse for the rest of the line activity.
REQ-038 Second start pulse during a frame -> ignored; the frame completes normally with data_valid.
REQ-039 Boundary widths: high phase of 50us+1 tick -> 1; exactly 50us -> 0.
